ram_bist_ctrl: RTL and testbench

Built-in self-test initiator for the team's single-port cs/rw RAM (32 words x 32 bits by default). On start, it drives the RAM's cs/rw/addr/data_in pins through a three-element march sequence and checks every read word against the expected value. It reports pass/fail, the first failing address and data, and an error count. It sits beside each RAM instance and muxes onto the RAM port only while busy; the mux is external to this block.

---
 rtl/ram_bist_ctrl.sv | 234 +++++++++++++++++++++++
 tb/tb_ram_bist_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl
// -------------
// Built-in self-test initiator for a single-port cs/rw RAM. When start is
// accepted it drives the RAM through a three-element march:
//    W_UP  : write P to every address, ascending
//    RW_UP : read each address expecting P, then write ~P to it, ascending
//    R_DN  : read each address expecting ~P, descending
// Every read word is compared against the expected value. The block reports
// pass/fail, the first failing address/data/element and a saturating error
// count. The RAM port mux that selects between this block and the functional
// user sits outside this module.
//
// Ports
//    clk         system clock, rising edge
//    reset       asynchronous active-high reset
//    start       launch a test (sampled only while idle)
//    pattern     background pattern, captured when start is accepted
//    busy        high while a test is running
//    done        one-cycle pulse at the end of a test
//    pass        high after done when no miscompare was seen
//    fail_addr   address of the first miscompare
//    fail_data   read data at the first miscompare
//    fail_phase  element of the first miscompare (1 = RW_UP, 2 = R_DN)
//    err_count   number of miscompares, saturating at all-ones
//    ram_cs      RAM chip select
//    ram_rw      RAM direction, 1 = write, 0 = read
//    ram_addr    RAM address
//    ram_wdata   RAM write data
//    ram_rdata   RAM read data
module ram_bist_ctrl #(
    parameter int N  = 32,
    parameter int M  = 5,
    parameter int EW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [N-1:0]  pattern,
    output logic          busy,
    output logic          done,
    output logic          pass,
    output logic [M-1:0]  fail_addr,
    output logic [N-1:0]  fail_data,
    output logic [1:0]    fail_phase,
    output logic [EW-1:0] err_count,
    output logic          ram_cs,
    output logic          ram_rw,
    output logic [M-1:0]  ram_addr,
    output logic [N-1:0]  ram_wdata,
    input  logic [N-1:0]  ram_rdata
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_W_UP,
        S_RW_RD,
        S_RW_WR,
        S_RD_RD,
        S_RD_CMP,
        S_DONE
    } state_t;

    localparam logic [M-1:0]  LAST_ADDR = '1;
    localparam logic [M-1:0]  ZERO_ADDR = '0;
    localparam logic [EW-1:0] ERR_MAX   = '1;
    localparam logic [1:0]    PHASE_RW  = 2'd1;
    localparam logic [1:0]    PHASE_RD  = 2'd2;

    state_t        state_q, state_d;
    logic [M-1:0]  addr_q, addr_d;
    logic [N-1:0]  pattern_q, pattern_d;
    logic          pass_q, pass_d;
    logic [EW-1:0] err_q, err_d;
    logic [M-1:0]  fail_addr_q, fail_addr_d;
    logic [N-1:0]  fail_data_q, fail_data_d;
    logic [1:0]    fail_phase_q, fail_phase_d;

    // Compare request for the current cycle: the word returned by the read
    // command issued in the previous cycle is checked at the closing edge.
    logic          check_en;
    logic [N-1:0]  check_exp;
    logic [1:0]    check_phase;

    // State and datapath registers. Reset aborts any test in flight and
    // returns every output to its idle value at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            addr_q       <= '0;
            pattern_q    <= '0;
            pass_q       <= 1'b0;
            err_q        <= '0;
            fail_addr_q  <= '0;
            fail_data_q  <= '0;
            fail_phase_q <= 2'd0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            pattern_q    <= pattern_d;
            pass_q       <= pass_d;
            err_q        <= err_d;
            fail_addr_q  <= fail_addr_d;
            fail_data_q  <= fail_data_d;
            fail_phase_q <= fail_phase_d;
        end
    end

    // March sequencer: next state, address walk and RAM command decode.
    // The address counter never wraps; each element ends on terminal-address
    // detection, and the descending element starts from the last address,
    // which is exactly where the ascending RW element stops.
    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        pattern_d    = pattern_q;
        pass_d       = pass_q;
        fail_addr_d  = fail_addr_q;
        fail_data_d  = fail_data_q;
        fail_phase_d = fail_phase_q;
        err_d        = err_q;
        busy         = 1'b0;
        done         = 1'b0;
        ram_cs       = 1'b0;
        ram_rw       = 1'b0;
        ram_wdata    = '0;
        check_en     = 1'b0;
        check_exp    = '0;
        check_phase  = 2'd0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pattern_d    = pattern;
                    pass_d       = 1'b0;
                    err_d        = '0;
                    fail_addr_d  = '0;
                    fail_data_d  = '0;
                    fail_phase_d = 2'd0;
                    addr_d       = '0;
                    state_d      = S_W_UP;
                end
            end
            S_W_UP: begin
                busy      = 1'b1;
                ram_cs    = 1'b1;
                ram_rw    = 1'b1;
                ram_wdata = pattern_q;
                if (addr_q == LAST_ADDR) begin
                    addr_d  = '0;
                    state_d = S_RW_RD;
                end else begin
                    addr_d = addr_q + 1'b1;
                end
            end
            S_RW_RD: begin
                busy      = 1'b1;
                ram_cs    = 1'b1;
                ram_rw    = 1'b0;
                ram_wdata = pattern_q;
                state_d   = S_RW_WR;
            end
            S_RW_WR: begin
                // Check the word read last cycle and overwrite it with the
                // complement in the same cycle.
                busy        = 1'b1;
                ram_cs      = 1'b1;
                ram_rw      = 1'b1;
                ram_wdata   = ~pattern_q;
                check_en    = 1'b1;
                check_exp   = pattern_q;
                check_phase = PHASE_RW;
                if (addr_q == LAST_ADDR) begin
                    state_d = S_RD_RD;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    state_d = S_RW_RD;
                end
            end
            S_RD_RD: begin
                busy    = 1'b1;
                ram_cs  = 1'b1;
                ram_rw  = 1'b0;
                state_d = S_RD_CMP;
            end
            S_RD_CMP: begin
                busy        = 1'b1;
                check_en    = 1'b1;
                check_exp   = ~pattern_q;
                check_phase = PHASE_RD;
                if (addr_q == ZERO_ADDR) begin
                    state_d = S_DONE;
                end else begin
                    addr_d  = addr_q - 1'b1;
                    state_d = S_RD_RD;
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Miscompare bookkeeping. A zero error count means no earlier
        // miscompare in this run, so that is when the failure details are
        // captured. The counter holds once it reaches all-ones.
        if (check_en && (ram_rdata != check_exp)) begin
            if (err_q == '0) begin
                fail_addr_d  = addr_q;
                fail_data_d  = ram_rdata;
                fail_phase_d = check_phase;
            end
            if (err_q != ERR_MAX) begin
                err_d = err_q + 1'b1;
            end
        end

        // The verdict includes the very last compare, taken on the same edge
        // that enters DONE.
        if ((state_q == S_RD_CMP) && (addr_q == ZERO_ADDR)) begin
            pass_d = (err_d == '0);
        end
    end

    assign pass       = pass_q;
    assign err_count  = err_q;
    assign fail_addr  = fail_addr_q;
    assign fail_data  = fail_data_q;
    assign fail_phase = fail_phase_q;
    assign ram_addr   = addr_q;

endmodule

// File: tb/tb_ram_bist_ctrl.sv
// Testbench for ram_bist_ctrl. Two instances share clock and reset: dutA
// uses default parameters, dutB uses a 2-bit error counter for the
// saturation case. Each drives its own behavioural RAM with injectable
// stuck-at faults. Expected results come from a march-level reference that
// walks the three elements over the fault map.
module tb_ram_bist_ctrl;

   localparam int N     = 32;
   localparam int M     = 5;
   localparam int DEPTH = 1 << M;
   localparam int LAT   = 5 * DEPTH;

   logic          clk;
   logic          reset;
   logic          startA, startB;
   logic [N-1:0]  patternIn;

   logic          busyA, doneA, passA, ramCsA, ramRwA;
   logic [M-1:0]  failAddrA, ramAddrA;
   logic [N-1:0]  failDataA, ramWdataA, ramRdataA;
   logic [1:0]    failPhaseA;
   logic [7:0]    errCountA;

   logic          busyB, doneB, passB, ramCsB, ramRwB;
   logic [M-1:0]  failAddrB, ramAddrB;
   logic [N-1:0]  failDataB, ramWdataB, ramRdataB;
   logic [1:0]    failPhaseB;
   logic [1:0]    errCountB;

   logic [N-1:0]  memA [DEPTH];
   logic [N-1:0]  memB [DEPTH];
   logic [N-1:0]  sa1Mask [DEPTH];
   logic [N-1:0]  sa0Mask [DEPTH];

   int            assertCount;
   int            failCount;
   int            sel;

   logic          obsBusy, obsDone, obsPass, obsCs, obsRw;
   logic [31:0]   obsErr, obsFailAddr, obsFailData, obsFailPhase, obsAddr, obsWdata;

   ram_bist_ctrl #(.N(N), .M(M), .EW(8)) dutA (
      .clk(clk), .reset(reset), .start(startA), .pattern(patternIn),
      .busy(busyA), .done(doneA), .pass(passA),
      .fail_addr(failAddrA), .fail_data(failDataA), .fail_phase(failPhaseA),
      .err_count(errCountA),
      .ram_cs(ramCsA), .ram_rw(ramRwA), .ram_addr(ramAddrA),
      .ram_wdata(ramWdataA), .ram_rdata(ramRdataA)
   );

   ram_bist_ctrl #(.N(N), .M(M), .EW(2)) dutB (
      .clk(clk), .reset(reset), .start(startB), .pattern(patternIn),
      .busy(busyB), .done(doneB), .pass(passB),
      .fail_addr(failAddrB), .fail_data(failDataB), .fail_phase(failPhaseB),
      .err_count(errCountB),
      .ram_cs(ramCsB), .ram_rw(ramRwB), .ram_addr(ramAddrB),
      .ram_wdata(ramWdataB), .ram_rdata(ramRdataB)
   );

   // Free-running clock, 10 time units per cycle.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stuck-at fault overlay applied to every word read out of a RAM.
   function automatic logic [N-1:0] faulty(input logic [N-1:0] v, input int a);
      return (v | sa1Mask[a]) & ~sa0Mask[a];
   endfunction

   // Behavioural RAMs: writes commit at the edge, reads return one cycle later.
   always @(posedge clk) begin
      if (ramCsA) begin
         if (ramRwA) memA[ramAddrA] <= ramWdataA;
         else        ramRdataA <= faulty(memA[ramAddrA], int'(ramAddrA));
      end
      if (ramCsB) begin
         if (ramRwB) memB[ramAddrB] <= ramWdataB;
         else        ramRdataB <= faulty(memB[ramAddrB], int'(ramAddrB));
      end
   end

   // Observation mux so one test procedure serves both instances.
   always_comb begin
      obsBusy      = (sel == 0) ? busyA : busyB;
      obsDone      = (sel == 0) ? doneA : doneB;
      obsPass      = (sel == 0) ? passA : passB;
      obsCs        = (sel == 0) ? ramCsA : ramCsB;
      obsRw        = (sel == 0) ? ramRwA : ramRwB;
      obsErr       = (sel == 0) ? {24'd0, errCountA} : {30'd0, errCountB};
      obsFailAddr  = (sel == 0) ? {27'd0, failAddrA} : {27'd0, failAddrB};
      obsFailData  = (sel == 0) ? failDataA : failDataB;
      obsFailPhase = (sel == 0) ? {30'd0, failPhaseA} : {30'd0, failPhaseB};
      obsAddr      = (sel == 0) ? {27'd0, ramAddrA} : {27'd0, ramAddrB};
      obsWdata     = (sel == 0) ? ramWdataA : ramWdataB;
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      assertCount++;
      if (observed !== expected) begin
         failCount++;
         $display("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic clearFaults();
      for (int a = 0; a < DEPTH; a++) begin
         sa1Mask[a] = '0;
         sa0Mask[a] = '0;
      end
   endtask

   // March-level reference: ascending reads expect P, descending reads
   // expect ~P; the first miscompare in time order is reported.
   task automatic computeExpected(input logic [N-1:0] pat, input int maxErr,
                                  output int expErr, output int expAddr,
                                  output logic [N-1:0] expData, output int expPhase);
      logic [N-1:0] r;
      int total;
      total    = 0;
      expAddr  = 0;
      expData  = '0;
      expPhase = 0;
      for (int a = 0; a < DEPTH; a++) begin
         r = faulty(pat, a);
         if (r != pat) begin
            if (total == 0) begin expAddr = a; expData = r; expPhase = 1; end
            total++;
         end
      end
      for (int a = DEPTH - 1; a >= 0; a--) begin
         r = faulty(~pat, a);
         if (r != ~pat) begin
            if (total == 0) begin expAddr = a; expData = r; expPhase = 2; end
            total++;
         end
      end
      expErr = (total > maxErr) ? maxErr : total;
   endtask

   task automatic pulseStart(input logic [N-1:0] pat);
      @(negedge clk);
      patternIn = pat;
      if (sel == 0) startA = 1'b1; else startB = 1'b1;
      @(posedge clk);
      #1;
      startA = 1'b0;
      startB = 1'b0;
   endtask

   // One complete test run with checks on launch, latency, results and RAM
   // contents. A nonzero midStart re-asserts start that many cycles in.
   task automatic applyStimulus(input string name, input logic [N-1:0] pat, input int midStart);
      int expErr, expAddr, expPhase, doneCycle, bad;
      logic [N-1:0] expData;
      computeExpected(pat, (sel == 0) ? 255 : 3, expErr, expAddr, expData, expPhase);
      pulseStart(pat);
      checkOutput({name, ".busyAtStart"}, {31'd0, obsBusy}, 32'd1);
      checkOutput({name, ".passCleared"}, {31'd0, obsPass}, 32'd0);
      checkOutput({name, ".errCleared"}, obsErr, 32'd0);
      doneCycle = -1;
      for (int n = 1; n <= LAT + 100; n++) begin
         @(posedge clk);
         #1;
         if (midStart != 0 && n == midStart) begin
            patternIn = ~pat;
            if (sel == 0) startA = 1'b1; else startB = 1'b1;
         end else begin
            startA = 1'b0;
            startB = 1'b0;
         end
         if (obsDone) begin
            doneCycle = n;
            break;
         end
      end
      startA = 1'b0;
      startB = 1'b0;
      checkOutput({name, ".doneLatency"}, doneCycle, LAT);
      checkOutput({name, ".busyAtDone"}, {31'd0, obsBusy}, 32'd0);
      checkOutput({name, ".csAtDone"}, {31'd0, obsCs}, 32'd0);
      checkOutput({name, ".pass"}, {31'd0, obsPass}, (expErr == 0) ? 32'd1 : 32'd0);
      checkOutput({name, ".errCount"}, obsErr, expErr);
      checkOutput({name, ".failAddr"}, obsFailAddr, expAddr);
      checkOutput({name, ".failData"}, obsFailData, expData);
      checkOutput({name, ".failPhase"}, obsFailPhase, expPhase);
      bad = 0;
      for (int a = 0; a < DEPTH; a++) begin
         if (sel == 0) begin if (memA[a] !== ~pat) bad++; end
         else          begin if (memB[a] !== ~pat) bad++; end
      end
      checkOutput({name, ".ramContent"}, bad, 0);
      @(posedge clk);
      #1;
      checkOutput({name, ".donePulse"}, {31'd0, obsDone}, 32'd0);
      checkOutput({name, ".passHold"}, {31'd0, obsPass}, (expErr == 0) ? 32'd1 : 32'd0);
   endtask

   initial begin
      logic [N-1:0] rp;
      int nf, fa, fb;
      assertCount = 0;
      failCount   = 0;
      sel         = 0;
      startA      = 1'b0;
      startB      = 1'b0;
      patternIn   = '0;
      clearFaults();
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checkOutput("reset.busy", {31'd0, obsBusy}, 32'd0);
      checkOutput("reset.done", {31'd0, obsDone}, 32'd0);
      checkOutput("reset.pass", {31'd0, obsPass}, 32'd0);
      checkOutput("reset.cs", {31'd0, obsCs}, 32'd0);
      checkOutput("reset.rw", {31'd0, obsRw}, 32'd0);
      checkOutput("reset.addr", obsAddr, 32'd0);
      checkOutput("reset.wdata", obsWdata, 32'd0);
      checkOutput("reset.err", obsErr, 32'd0);
      checkOutput("reset.failData", obsFailData, 32'd0);
      @(negedge clk);
      reset = 1'b0;

      $display("[TB] fault-free run");
      applyStimulus("clean", 32'hA5A5A5A5, 0);

      $display("[TB] stuck-at-1 bit 3 at address 7");
      sa1Mask[7] = 32'h0000_0008;
      applyStimulus("sa1", 32'hA5A5A5A5, 0);
      clearFaults();

      $display("[TB] stuck-at-0 bit 0 at addresses 31 and 2");
      sa0Mask[31] = 32'h0000_0001;
      sa0Mask[2]  = 32'h0000_0001;
      applyStimulus("sa0", 32'h0000_0000, 0);
      clearFaults();

      $display("[TB] start while busy, then restart");
      applyStimulus("busyStart", 32'h3C3C_0FF0, 50);
      applyStimulus("restart", 32'hDEAD_BEEF, 0);

      $display("[TB] reset in the middle of the RW element");
      sa1Mask[7] = 32'h0000_0008;
      pulseStart(32'hA5A5A5A5);
      repeat (69) @(posedge clk);
      #1;
      checkOutput("midReset.errBefore", obsErr, 32'd1);
      reset = 1'b1;
      #1;
      checkOutput("midReset.busy", {31'd0, obsBusy}, 32'd0);
      checkOutput("midReset.cs", {31'd0, obsCs}, 32'd0);
      checkOutput("midReset.err", obsErr, 32'd0);
      checkOutput("midReset.failAddr", obsFailAddr, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      clearFaults();
      applyStimulus("afterReset", 32'hA5A5A5A5, 0);

      $display("[TB] error counter saturation on narrow counter");
      sel = 1;
      for (int a = 0; a < DEPTH; a++) sa1Mask[a] = 32'h0000_0001;
      applyStimulus("saturate", 32'h0000_0000, 0);
      clearFaults();
      sel = 0;

      $display("[TB] randomized fault maps");
      for (int t = 0; t < 5; t++) begin
         rp = $urandom;
         nf = $urandom_range(0, 3);
         for (int k = 0; k < nf; k++) begin
            fa = $urandom_range(0, DEPTH - 1);
            fb = $urandom_range(0, N - 1);
            if ($urandom_range(0, 1) == 1) sa1Mask[fa][fb] = 1'b1;
            else                           sa0Mask[fa][fb] = 1'b1;
         end
         applyStimulus($sformatf("rand%0d", t), rp, 0);
         clearFaults();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
      $finish;
   end

endmodule
